// File: rtl/port_rd_checker.sv
// Consumer for one switch read port: pulses ready, parses the returned packet,
// checks header dest/len and an incrementing payload, and reports latency and errors.
module port_rd_checker #(
  parameter int PORT_ID = 0,
  parameter int TIMEOUT = 4095,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic             ready,
  input  logic             rd_sop,
  input  logic             rd_vld,
  input  logic [15:0]      rd_data,
  input  logic             rd_eop,
  output logic             rpt_vld,
  output logic [8:0]       rpt_len,
  output logic [2:0]       rpt_prior,
  output logic [15:0]      rpt_latency,
  output logic [15:0]      rpt_duration,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [4:0]       err_sticky
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0] PID = 4'(PORT_ID);
  localparam int E_PROTO = 4;
  localparam int E_TMO   = 3;
  localparam int E_DEST  = 2;
  localparam int E_LEN   = 1;
  localparam int E_DATA  = 0;

  typedef enum logic [2:0] {IDLE, WAIT_SOP, WAIT_HDR, PAYLOAD, REPORT} state_t;

  state_t            state_q, state_d;
  logic              en_q;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [15:0]       lat_q, lat_d, lat_inc;
  logic [9:0]        idx_q, idx_d, idx_inc, eff_idx;
  logic [8:0]        len_q, len_d;
  logic [2:0]        prior_q, prior_d;
  logic [15:0]       hlat_q, hlat_d;
  logic [4:0]        pkt_err_q, pkt_err_d, pkt_set, stk_set;
  logic              pkt_clr, tmo_evt;
  logic [4:0]        sticky_q, sticky_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
  logic [8:0]        rpt_len_q, rpt_len_d;
  logic [2:0]        rpt_prior_q, rpt_prior_d;
  logic [15:0]       rpt_lat_q, rpt_lat_d, rpt_dur_q, rpt_dur_d;

  assign lat_inc = (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;
  assign idx_inc = (idx_q == 10'h3FF) ? idx_q : idx_q + 10'd1;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    lat_d       = lat_inc;
    idx_d       = idx_q;
    eff_idx     = idx_q;
    len_d       = len_q;
    prior_d     = prior_q;
    hlat_d      = hlat_q;
    pkt_clr     = 1'b0;
    pkt_set     = '0;
    stk_set     = '0;
    tmo_evt     = 1'b0;
    rpt_len_d   = rpt_len_q;
    rpt_prior_d = rpt_prior_q;
    rpt_lat_d   = rpt_lat_q;
    rpt_dur_d   = rpt_dur_q;

    case (state_q)
      IDLE: begin
        if (en_q) begin
          tmo_d   = '0;
          state_d = WAIT_SOP;
        end
      end
      WAIT_SOP: begin
        if (rd_vld || rd_eop) stk_set[E_PROTO] = 1'b1;
        // The sop cycle counts as 0, so the cycle after it reads 1.
        if (rd_sop) begin
          lat_d   = 16'd1;
          pkt_clr = 1'b1;
          len_d   = '0;
          prior_d = '0;
          hlat_d  = '0;
          state_d = WAIT_HDR;
        end else if (tmo_q == TO_LAST) begin
          tmo_evt = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_HDR: begin
        if (rd_sop) begin
          stk_set[E_PROTO] = 1'b1;
          lat_d   = 16'd1;
          pkt_clr = 1'b1;
        end else if (rd_vld) begin
          len_d   = rd_data[15:7];
          prior_d = rd_data[6:4];
          hlat_d  = lat_q;
          idx_d   = '0;
          if (rd_data[3:0] != PID) pkt_set[E_DEST] = 1'b1;
          if (rd_eop) begin
            if (rd_data[15:7] != 9'd0) pkt_set[E_LEN] = 1'b1;
            state_d = REPORT;
          end else begin
            state_d = PAYLOAD;
          end
        end else if (rd_eop) begin
          pkt_set[E_PROTO] = 1'b1;
          state_d = REPORT;
        end
      end
      PAYLOAD: begin
        // A new sop abandons the packet in flight and reuses the header path.
        if (rd_sop) begin
          stk_set[E_PROTO] = 1'b1;
          lat_d   = 16'd1;
          pkt_clr = 1'b1;
          len_d   = '0;
          prior_d = '0;
          hlat_d  = '0;
          state_d = WAIT_HDR;
        end else begin
          if (rd_vld) begin
            if (rd_data != {6'b0, idx_q}) pkt_set[E_DATA] = 1'b1;
            eff_idx = idx_inc;
            idx_d   = idx_inc;
          end
          if (rd_eop) begin
            if (eff_idx != {1'b0, len_q}) pkt_set[E_LEN] = 1'b1;
            state_d = REPORT;
          end
        end
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_d == REPORT) && (state_q != REPORT)) begin
      rpt_len_d   = len_d;
      rpt_prior_d = prior_d;
      rpt_lat_d   = hlat_d;
      rpt_dur_d   = lat_inc;
    end
  end

  always_comb begin
    pkt_err_d = (pkt_clr ? 5'b0 : pkt_err_q) | pkt_set;
    sticky_d  = sticky_q | pkt_set | stk_set | {1'b0, tmo_evt, 3'b0};
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (state_q == REPORT) begin
      pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      if (|pkt_err_q) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
    if (tmo_evt) err_cnt_d = err_cnt_q + CNT_W'(1);
    if (clr) begin
      sticky_d  = '0;
      pkt_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      tmo_q       <= '0;
      lat_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      prior_q     <= '0;
      hlat_q      <= '0;
      pkt_err_q   <= '0;
      sticky_q    <= '0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
      rpt_len_q   <= '0;
      rpt_prior_q <= '0;
      rpt_lat_q   <= '0;
      rpt_dur_q   <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en;
      tmo_q       <= tmo_d;
      lat_q       <= lat_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      prior_q     <= prior_d;
      hlat_q      <= hlat_d;
      pkt_err_q   <= pkt_err_d;
      sticky_q    <= sticky_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
      rpt_len_q   <= rpt_len_d;
      rpt_prior_q <= rpt_prior_d;
      rpt_lat_q   <= rpt_lat_d;
      rpt_dur_q   <= rpt_dur_d;
    end
  end

  // en is registered so ready stays low throughout reset regardless of en.
  assign ready        = en_q && (state_q == IDLE);
  assign rpt_vld      = (state_q == REPORT);
  assign rpt_len      = rpt_len_q;
  assign rpt_prior    = rpt_prior_q;
  assign rpt_latency  = rpt_lat_q;
  assign rpt_duration = rpt_dur_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign err_cnt      = err_cnt_q;
  assign err_sticky   = sticky_q;

endmodule

// File: tb/tb_port_rd_checker.sv
// Self-checking bench for port_rd_checker: directed scenarios plus randomized
// packets compared against a word-list reference model.
module tb_port_rd_checker;
  localparam int PORT_ID = 3;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0, clr = 1'b0;
  logic rd_sop = 1'b0, rd_vld = 1'b0, rd_eop = 1'b0;
  logic [15:0] rd_data = '0;
  logic ready, rpt_vld;
  logic [8:0] rpt_len;
  logic [2:0] rpt_prior;
  logic [15:0] rpt_latency, rpt_duration;
  logic [CNT_W-1:0] pkt_cnt, err_cnt;
  logic [4:0] err_sticky;

  int checks = 0, failures = 0;
  int cyc = 0;
  int rpt_seen = 0, ready_long = 0;
  logic prev_ready = 1'b0;
  logic [15:0] pkt_words[$];

  port_rd_checker #(.PORT_ID(PORT_ID), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .ready(ready),
    .rd_sop(rd_sop), .rd_vld(rd_vld), .rd_data(rd_data), .rd_eop(rd_eop),
    .rpt_vld(rpt_vld), .rpt_len(rpt_len), .rpt_prior(rpt_prior),
    .rpt_latency(rpt_latency), .rpt_duration(rpt_duration),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rpt_vld === 1'b1) rpt_seen++;
    if (ready === 1'b1 && prev_ready === 1'b1) ready_long++;
    prev_ready = ready;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive_cycle(input bit sop, input bit vld, input logic [15:0] data, input bit eop);
    rd_sop = sop; rd_vld = vld; rd_data = data; rd_eop = eop;
    @(negedge clk);
    rd_sop = 1'b0; rd_vld = 1'b0; rd_data = '0; rd_eop = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ready(input int limit, output int at, output bit ok);
    ok = 1'b0; at = -1;
    for (int n = 0; n < limit; n++) begin
      if (ready === 1'b1) begin
        ok = 1'b1; at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic fill_words(input int n, input int cidx, input logic [15:0] cval);
    pkt_words.delete();
    for (int i = 0; i < n; i++) pkt_words.push_back((i == cidx) ? cval : 16'(i));
  endtask

  // Reference: what the packet's own error bits must be, from its word list.
  function automatic logic [4:0] expect_err(input logic [8:0] len, input logic [3:0] dest);
    logic [4:0] e;
    e = '0;
    for (int i = 0; i < pkt_words.size(); i++)
      if (pkt_words[i] != 16'(i)) e[0] = 1'b1;
    if (pkt_words.size() != int'(len)) e[1] = 1'b1;
    if (dest != 4'(PORT_ID)) e[2] = 1'b1;
    return e;
  endfunction

  // Called at the negedge where ready was seen; returns at the negedge after eop.
  task automatic send_packet(input logic [15:0] hdr, input int sop_delay, input int hdr_gap,
                             input int max_gap, input bit eop_with_last,
                             output int dur, output int eop_cyc);
    int n, g;
    n = 0;
    repeat (sop_delay) @(negedge clk);
    drive_cycle(1'b1, 1'b0, '0, 1'b0); n++;
    repeat (hdr_gap) begin drive_cycle(1'b0, 1'b0, '0, 1'b0); n++; end
    drive_cycle(1'b0, 1'b1, hdr, 1'b0); n++;
    for (int i = 0; i < pkt_words.size(); i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin drive_cycle(1'b0, 1'b0, '0, 1'b0); n++; end
      if (eop_with_last && i == pkt_words.size() - 1) begin
        eop_cyc = cyc;
        drive_cycle(1'b0, 1'b1, pkt_words[i], 1'b1); n++;
      end else begin
        drive_cycle(1'b0, 1'b1, pkt_words[i], 1'b0); n++;
      end
    end
    if (!(eop_with_last && pkt_words.size() > 0)) begin
      eop_cyc = cyc;
      drive_cycle(1'b0, 1'b0, '0, 1'b1); n++;
    end
    dur = n;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({ready, rpt_vld, rpt_len, rpt_prior, rpt_latency, rpt_duration, pkt_cnt, err_cnt, err_sticky} !== '0) begin
      failures++; $display("[TB] FAIL reset_outputs: got ready=%b rpt_vld=%b pkt=%0d err=%0d sticky=%b expected all 0",
                           ready, rpt_vld, pkt_cnt, err_cnt, err_sticky); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_no_ready_when_disabled: got %b expected 0", ready); end
  endtask

  task automatic test_basic();
    int at, dur, ec, r0; bit ok;
    do_reset(); r0 = rpt_seen; en = 1'b1;
    wait_ready(10, at, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL basic_ready: got none expected pulse"); end
    fill_words(31, -1, '0);
    send_packet({9'd31, 3'd2, 4'd3}, 5, 0, 0, 1'b0, dur, ec);
    en = 1'b0;
    @(negedge clk);
    checks++; if (rpt_seen - r0 != 1) begin failures++; $display("[TB] FAIL basic_rpt_count: got %0d expected 1", rpt_seen - r0); end
    checks++; if (rpt_len !== 9'd31) begin failures++; $display("[TB] FAIL basic_len: got %0d expected 31", rpt_len); end
    checks++; if (rpt_prior !== 3'd2) begin failures++; $display("[TB] FAIL basic_prior: got %0d expected 2", rpt_prior); end
    checks++; if (rpt_latency !== 16'd1) begin failures++; $display("[TB] FAIL basic_latency: got %0d expected 1", rpt_latency); end
    checks++; if (rpt_duration !== 16'd34 || dur != 34) begin failures++; $display("[TB] FAIL basic_duration: got %0d expected 34", rpt_duration); end
    checks++; if (pkt_cnt !== 1) begin failures++; $display("[TB] FAIL basic_pkt_cnt: got %0d expected 1", pkt_cnt); end
    checks++; if (err_sticky !== 5'b0) begin failures++; $display("[TB] FAIL basic_sticky: got %b expected 00000", err_sticky); end
  endtask

  task automatic test_back_to_back();
    int at, dur, ec; bit ok;
    do_reset(); en = 1'b1;
    wait_ready(10, at, ok);
    fill_words(511, -1, '0);
    send_packet({9'd511, 3'd5, 4'd3}, 2, 0, 0, 1'b0, dur, ec);
    wait_ready(10, at, ok);
    en = 1'b0;
    checks++; if (!ok || at - ec != 2) begin failures++; $display("[TB] FAIL b2b_ready_gap: got %0d expected 2", at - ec); end
    checks++; if (rpt_duration !== 16'd514) begin failures++; $display("[TB] FAIL b2b_duration: got %0d expected 514", rpt_duration); end
    checks++; if (err_sticky !== 5'b0 || err_cnt !== 0) begin failures++; $display("[TB] FAIL b2b_errors: got sticky=%b err=%0d expected 0", err_sticky, err_cnt); end
  endtask

  task automatic test_data_error();
    int at, dur, ec; bit ok;
    do_reset(); en = 1'b1;
    wait_ready(10, at, ok);
    fill_words(31, 7, 16'hFFFF);
    send_packet({9'd31, 3'd0, 4'd3}, 3, 0, 0, 1'b0, dur, ec);
    @(negedge clk);
    checks++; if (err_sticky !== expect_err(9'd31, 4'd3) || err_sticky !== 5'b00001) begin
      failures++; $display("[TB] FAIL data_sticky: got %b expected 00001", err_sticky); end
    checks++; if (err_cnt !== 1) begin failures++; $display("[TB] FAIL data_err_cnt: got %0d expected 1", err_cnt); end
    wait_ready(10, at, ok);
    fill_words(31, -1, '0);
    send_packet({9'd31, 3'd1, 4'd3}, 3, 0, 0, 1'b1, dur, ec);
    en = 1'b0;
    @(negedge clk);
    checks++; if (err_cnt !== 1 || pkt_cnt !== 2) begin failures++; $display("[TB] FAIL data_clean_follow: got err=%0d pkt=%0d expected 1 2", err_cnt, pkt_cnt); end
  endtask

  task automatic test_len_dest();
    int at, dur, ec; bit ok;
    do_reset(); en = 1'b1;
    wait_ready(10, at, ok);
    fill_words(39, -1, '0);
    send_packet({9'd40, 3'd0, 4'd3}, 1, 0, 0, 1'b0, dur, ec);
    @(negedge clk);
    checks++; if (err_sticky !== 5'b00010) begin failures++; $display("[TB] FAIL len_sticky: got %b expected 00010", err_sticky); end
    wait_ready(10, at, ok);
    fill_words(31, -1, '0);
    send_packet({9'd31, 3'd0, 4'd5}, 1, 0, 0, 1'b0, dur, ec);
    en = 1'b0;
    @(negedge clk);
    checks++; if (err_sticky !== 5'b00110) begin failures++; $display("[TB] FAIL dest_sticky: got %b expected 00110", err_sticky); end
    checks++; if (err_cnt !== 2) begin failures++; $display("[TB] FAIL len_dest_err_cnt: got %0d expected 2", err_cnt); end
  endtask

  task automatic test_timeout();
    int at1, at2, r0; bit ok1, ok2;
    do_reset(); r0 = rpt_seen; en = 1'b1;
    wait_ready(10, at1, ok1);
    @(negedge clk);
    wait_ready(4 * TIMEOUT, at2, ok2);
    en = 1'b0;
    checks++; if (!ok1 || !ok2 || at2 - at1 != TIMEOUT + 1) begin
      failures++; $display("[TB] FAIL timeout_rerequest: got gap %0d expected %0d", at2 - at1, TIMEOUT + 1); end
    checks++; if (err_sticky !== 5'b01000) begin failures++; $display("[TB] FAIL timeout_sticky: got %b expected 01000", err_sticky); end
    checks++; if (err_cnt !== 1) begin failures++; $display("[TB] FAIL timeout_err_cnt: got %0d expected 1", err_cnt); end
    checks++; if (rpt_seen != r0) begin failures++; $display("[TB] FAIL timeout_no_report: got %0d expected 0", rpt_seen - r0); end
  endtask

  task automatic test_mid_sop();
    int at, dur, ec, r0; bit ok;
    do_reset(); r0 = rpt_seen; en = 1'b1;
    wait_ready(10, at, ok);
    repeat (2) @(negedge clk);
    drive_cycle(1'b1, 1'b0, '0, 1'b0);
    drive_cycle(1'b0, 1'b1, {9'd31, 3'd4, 4'd3}, 1'b0);
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b1, 16'(i), 1'b0);
    fill_words(31, -1, '0);
    send_packet({9'd31, 3'd2, 4'd3}, 0, 0, 0, 1'b0, dur, ec);
    en = 1'b0;
    @(negedge clk);
    checks++; if (rpt_seen - r0 != 1) begin failures++; $display("[TB] FAIL midsop_rpt_count: got %0d expected 1", rpt_seen - r0); end
    checks++; if (err_sticky !== 5'b10000) begin failures++; $display("[TB] FAIL midsop_sticky: got %b expected 10000", err_sticky); end
    checks++; if (rpt_prior !== 3'd2 || rpt_latency !== 16'd1 || rpt_duration !== 16'(dur)) begin
      failures++; $display("[TB] FAIL midsop_report: got prior=%0d lat=%0d dur=%0d expected 2 1 %0d", rpt_prior, rpt_latency, rpt_duration, dur); end
  endtask

  task automatic test_reset_mid_packet();
    int at, dur, ec; bit ok;
    do_reset(); en = 1'b1;
    wait_ready(10, at, ok);
    fill_words(8, -1, '0);
    send_packet({9'd8, 3'd6, 4'd3}, 1, 0, 0, 1'b0, dur, ec);
    wait_ready(10, at, ok);
    @(negedge clk);
    drive_cycle(1'b1, 1'b0, '0, 1'b0);
    drive_cycle(1'b0, 1'b1, {9'd20, 3'd1, 4'd3}, 1'b0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 16'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if ({ready, rpt_vld, rpt_len, rpt_prior, rpt_latency, rpt_duration, pkt_cnt, err_cnt, err_sticky} !== '0) begin
      failures++; $display("[TB] FAIL midreset_outputs: got len=%0d dur=%0d pkt=%0d ready=%b expected all 0",
                           rpt_len, rpt_duration, pkt_cnt, ready); end
    @(negedge clk); rst_n = 1'b1;
    wait_ready(5, at, ok);
    en = 1'b0;
    checks++; if (!ok) begin failures++; $display("[TB] FAIL midreset_ready_after: got none expected pulse"); end
  endtask

  task automatic test_random();
    int at, dur, ec, len, nw, cidx, exp_pkt, exp_errc; bit ok, ewl;
    logic [3:0] dest; logic [2:0] prior; logic [4:0] e, exp_stk;
    do_reset(); en = 1'b1;
    exp_pkt = 0; exp_errc = 0; exp_stk = '0;
    for (int k = 0; k < 20; k++) begin
      int hgap;
      wait_ready(20, at, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL rand_ready[%0d]: got none expected pulse", k); end
      len = $urandom_range(40, 0);
      case ($urandom_range(3, 0))
        0: nw = len + 1;
        1: nw = (len > 0) ? len - 1 : len;
        default: nw = len;
      endcase
      dest  = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'(PORT_ID);
      prior = 3'($urandom_range(7, 0));
      cidx  = ($urandom_range(2, 0) == 0 && nw > 0) ? int'($urandom_range(nw - 1, 0)) : -1;
      fill_words(nw, cidx, 16'($urandom));
      ewl   = (nw > 0) && ($urandom_range(1, 0) == 1);
      hgap  = $urandom_range(3, 0);
      send_packet({9'(len), prior, dest}, $urandom_range(8, 1), hgap, $urandom_range(2, 0), ewl, dur, ec);
      if (k == 10) clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      e = expect_err(9'(len), dest);
      if (k == 10) begin
        exp_pkt = 0; exp_errc = 0; exp_stk = '0;
      end else begin
        exp_pkt++;
        if (e != 5'b0) exp_errc++;
        exp_stk = exp_stk | e;
      end
      checks++; if (rpt_len !== 9'(len) || rpt_prior !== prior) begin
        failures++; $display("[TB] FAIL rand_hdr[%0d]: got len=%0d prior=%0d expected %0d %0d", k, rpt_len, rpt_prior, len, prior); end
      checks++; if (rpt_latency !== 16'(hgap + 1) || rpt_duration !== 16'(dur)) begin
        failures++; $display("[TB] FAIL rand_timing[%0d]: got lat=%0d dur=%0d expected %0d %0d", k, rpt_latency, rpt_duration, hgap + 1, dur); end
      checks++; if (pkt_cnt !== CNT_W'(exp_pkt) || err_cnt !== CNT_W'(exp_errc)) begin
        failures++; $display("[TB] FAIL rand_counters[%0d]: got pkt=%0d err=%0d expected %0d %0d", k, pkt_cnt, err_cnt, exp_pkt, exp_errc); end
      checks++; if (err_sticky !== exp_stk) begin
        failures++; $display("[TB] FAIL rand_sticky[%0d]: got %b expected %b", k, err_sticky, exp_stk); end
    end
    en = 1'b0;
    checks++; if (ready_long != 0) begin failures++; $display("[TB] FAIL ready_width: got %0d long pulses expected 0", ready_long); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_data_error();
    test_len_dest();
    test_timeout();
    test_mid_sop();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
